photon_frame_counter: RTL

Multi-channel, parametrised photon counter for single-pixel imaging. It counts rising edges on N_CH asynchronous detector inputs between DMD frame triggers. On each trigger it latches the per-channel counts and a frame index into an internal FIFO, then restarts counting. It sits between the detector front-end and the readout path and replaces the single 16-bit counter plus frame memory pair with one buffered block.

---
 rtl/photon_frame_counter.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/photon_frame_counter.sv
// -----------------------------------------------------------------------------
// photon_frame_counter
//
// Counts rising edges on N_CH asynchronous photon-detector inputs between DMD
// frame triggers. Each trigger snapshots the per-channel counts, their
// saturation bits and the running frame index into a FIFO, then restarts the
// counters for the next frame. The FIFO is read one entry per rd_en.
//
// Ports
//   clk50Mhz  in   system clock
//   rst       in   asynchronous, active-high reset
//   sig       in   [N_CH]        asynchronous photon pulses, one per channel
//   DMD_sig   in                 asynchronous frame trigger (rising edge)
//   enable    in                 acquisition enable
//   clr_ovf   in                 clear sticky overflow flag
//   rd_en     in                 pop request
//   rd_data   out  [N_CH*CNT_W]  popped counts, channel k at [k*CNT_W +: CNT_W]
//   rd_frame  out  [FRAME_W]     frame index of popped entry
//   rd_valid  out                rd_data/rd_frame/sat valid this cycle
//   sat       out  [N_CH]        per-channel saturation of popped entry
//   empty     out                FIFO empty
//   full      out                FIFO holds DEPTH entries
//   level     out  [clog2+1]     entries held
//   overflow  out                sticky: a frame was dropped
// -----------------------------------------------------------------------------
module photon_frame_counter #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 16,
  parameter int FRAME_W     = 16,
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk50Mhz,
  input  logic                      rst,
  input  logic [N_CH-1:0]           sig,
  input  logic                      DMD_sig,
  input  logic                      enable,
  input  logic                      clr_ovf,
  input  logic                      rd_en,
  output logic [N_CH*CNT_W-1:0]     rd_data,
  output logic [FRAME_W-1:0]        rd_frame,
  output logic                      rd_valid,
  output logic [N_CH-1:0]           sat,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int DATA_W  = N_CH * CNT_W;
  localparam int ENTRY_W = DATA_W + FRAME_W + N_CH;

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);
  localparam logic [AW-1:0]      PTR_ONE   = AW'(1);
  localparam logic [LW-1:0]      LVL_ONE   = LW'(1);
  localparam logic [LW-1:0]      LVL_FULL  = LW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detectors
  // Stage 0 takes the raw input; the last stage is compared with one extra
  // delay flop to form a single-cycle rising-edge pulse.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_CH-1:0] r_sig_sync;
  logic [N_CH-1:0]                  r_sig_dly;
  logic [SYNC_STAGES-1:0]           r_dmd_sync;
  logic                             r_dmd_dly;

  logic [N_CH-1:0] w_sig_edge;
  logic            w_trig;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser chain into a single flop.
  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      r_sig_sync <= '0;
      r_sig_dly  <= '0;
      r_dmd_sync <= '0;
      r_dmd_dly  <= 1'b0;
    end else begin
      r_sig_sync <= {r_sig_sync[SYNC_STAGES-2:0], sig};
      r_sig_dly  <= r_sig_sync[SYNC_STAGES-1];
      r_dmd_sync <= {r_dmd_sync[SYNC_STAGES-2:0], DMD_sig};
      r_dmd_dly  <= r_dmd_sync[SYNC_STAGES-1];
    end
  end

  assign w_sig_edge = r_sig_sync[SYNC_STAGES-1] & ~r_sig_dly;
  // Triggers seen while acquisition is disabled are discarded outright.
  assign w_trig     = enable & r_dmd_sync[SYNC_STAGES-1] & ~r_dmd_dly;

  // ---------------------------------------------------------------------------
  // Per-channel saturating counters and running frame index
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0][CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]            r_sat_run;
  logic [FRAME_W-1:0]         r_frame_idx;

  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_sat_run <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (!enable) begin
          r_cnt[k]     <= '0;
          r_sat_run[k] <= 1'b0;
        end else if (w_trig) begin
          // A photon coinciding with the trigger opens the new frame.
          r_cnt[k]     <= CNT_W'(w_sig_edge[k]);
          r_sat_run[k] <= 1'b0;
        end else if (w_sig_edge[k]) begin
          if (r_cnt[k] == CNT_MAX) begin
            r_sat_run[k] <= 1'b1;
          end else begin
            r_cnt[k] <= r_cnt[k] + CNT_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      r_frame_idx <= '0;
    end else if (w_trig) begin
      r_frame_idx <= r_frame_idx + FRAME_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot stage: the closing frame is captured on the trigger and offered
  // to the FIFO on the following cycle, where the accept/drop decision is made.
  // ---------------------------------------------------------------------------
  logic                       r_snap_vld;
  logic [N_CH-1:0][CNT_W-1:0] r_snap_cnt;
  logic [N_CH-1:0]            r_snap_sat;
  logic [FRAME_W-1:0]         r_snap_frame;

  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      r_snap_vld   <= 1'b0;
      r_snap_cnt   <= '0;
      r_snap_sat   <= '0;
      r_snap_frame <= '0;
    end else begin
      r_snap_vld <= w_trig;
      if (w_trig) begin
        r_snap_cnt   <= r_cnt;
        r_snap_sat   <= r_sat_run;
        r_snap_frame <= r_frame_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LW-1:0]      r_level;
  logic               r_empty;
  logic               r_full;
  logic               r_overflow;

  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [LW-1:0]      w_level_nxt;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;

  assign w_pop  = rd_en & ~r_empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the entry.
  assign w_push = r_snap_vld & (~r_full | w_pop);
  assign w_drop = r_snap_vld & r_full & ~w_pop;

  assign w_wr_entry = {r_snap_sat, r_snap_frame, r_snap_cnt};
  assign w_rd_entry = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and level, so clearing it would only add a reset net to every bit.
  always_ff @(posedge clk50Mhz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // any path leaving w_level_nxt unassigned would infer a latch.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LVL_FULL);
    end
  end

  // Read port: one-cycle latency, data held between pops.
  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_frame <= '0;
      sat      <= '0;
    end else begin
      rd_valid <= w_pop;
      if (w_pop) begin
        rd_data  <= w_rd_entry[DATA_W-1:0];
        rd_frame <= w_rd_entry[DATA_W +: FRAME_W];
        sat      <= w_rd_entry[DATA_W+FRAME_W +: N_CH];
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set.
  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign empty    = r_empty;
  assign full     = r_full;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule
